mul_div_unit: RTL and testbench

- Iterative multiply/divide unit for the MIPS datapath; the producer side of the HI/LO register pair.
- Accepts MULT/MULTU/DIV/DIVU/MADD/MSUB from the execute stage and computes over a fixed multi-cycle schedule.
- Delivers the 64-bit result as HI/LO write data with one-cycle hi_write/lo_write strobes.
- Reports busy so the hazard unit can stall mfhi/mflo and further mult/div issue.

---
 rtl/mdu_pkg.sv | 37 +++
 rtl/mdu_iter_step.sv | 55 +++++
 rtl/mul_div_unit.sv | 235 +++++++++++++++++++++++
 tb/tb_mul_div_unit.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// ---------------------------------------------------------------------------
// mdu_pkg
// Shared definitions for the iterative multiply/divide unit: operation
// encodings, FSM state encoding, the default datapath width and the LO value
// returned when a divide sees a zero divisor.
// ---------------------------------------------------------------------------
package mdu_pkg;

    // Default operand and HI/LO width
    localparam int MDU_WIDTH = 32;

    // Operation encodings as driven by the execute stage
    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MADD  = 3'b100;
    localparam logic [2:0] OP_MSUB  = 3'b101;

    // LO result of any divide whose divisor is zero
    localparam logic [MDU_WIDTH-1:0] DIV0_LO = 32'hFFFF_FFFF;

    // Operation schedule
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PREP  = 3'd1,
        ST_CALC  = 3'd2,
        ST_FIX   = 3'd3,
        ST_WRITE = 3'd4
    } mdu_state_e;

    // Encodings 110 and 111 are not operations and must never start the unit
    function automatic logic opIsLegal(input logic [2:0] opCode);
        return (opCode <= OP_MSUB);
    endfunction

endpackage

// File: rtl/mdu_iter_step.sv
// ---------------------------------------------------------------------------
// mdu_iter_step
// One iteration of the unsigned multiply/divide datapath, purely
// combinational.  The accumulator pair {accHi, accLo} is interpreted as:
//   multiply: accHi = partial product upper half, accLo = remaining
//             multiplier bits (LSB consumed first, product bits shift in
//             from the top)
//   divide:   accHi = partial remainder, accLo = dividend bits still to be
//             consumed (MSB first) with quotient bits shifting in at LSB
//
// Ports:
//   isDiv_i   1      select divide (trial subtract) vs multiply (shift-add)
//   accHi_i   WIDTH  current upper accumulator
//   accLo_i   WIDTH  current lower accumulator
//   opnd_i    WIDTH  multiplicand magnitude or divisor magnitude
//   accHi_o   WIDTH  next upper accumulator
//   accLo_o   WIDTH  next lower accumulator
// ---------------------------------------------------------------------------
module mdu_iter_step #(
    parameter int WIDTH = 32
) (
    input  logic             isDiv_i,
    input  logic [WIDTH-1:0] accHi_i,
    input  logic [WIDTH-1:0] accLo_i,
    input  logic [WIDTH-1:0] opnd_i,
    output logic [WIDTH-1:0] accHi_o,
    output logic [WIDTH-1:0] accLo_o
);

    logic [WIDTH:0] addSum;
    logic [WIDTH:0] shiftedRem;
    logic [WIDTH:0] trialDiff;

    // The extra bit on addSum keeps the carry so it can shift back into the
    // upper half; on trialDiff the extra bit is the borrow, which means the
    // divisor did not fit and the previous remainder must be restored.
    always_comb begin
        addSum     = {1'b0, accHi_i} + (accLo_i[0] ? {1'b0, opnd_i} : '0);
        shiftedRem = {accHi_i, accLo_i[WIDTH-1]};
        trialDiff  = shiftedRem - {1'b0, opnd_i};
        accHi_o    = addSum[WIDTH:1];
        accLo_o    = {addSum[0], accLo_i[WIDTH-1:1]};

        if (isDiv_i) begin
            if (!trialDiff[WIDTH]) begin
                accHi_o = trialDiff[WIDTH-1:0];
                accLo_o = {accLo_i[WIDTH-2:0], 1'b1};
            end else begin
                accHi_o = shiftedRem[WIDTH-1:0];
                accLo_o = {accLo_i[WIDTH-2:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/mul_div_unit.sv
// ---------------------------------------------------------------------------
// mul_div_unit
// Iterative multiply/divide unit feeding the HI/LO register pair.  Every
// legal operation follows the same fixed schedule:
//   PREP (1) -> CALC (WIDTH) -> FIX (1) -> WRITE (1)
// so the write strobes appear in the 35th cycle after the start edge.
// Signed operations run on magnitudes; signs are recorded in PREP and the
// two's-complement correction (and MADD/MSUB accumulation) happens in FIX.
//
// Ports:
//   Clk       in   rising-edge clock
//   Rst_n     in   asynchronous active-low reset
//   start     in   operation request, only honoured in IDLE
//   flush     in   synchronous kill of the in-flight operation
//   op        in   operation code (see mdu_pkg)
//   a, b      in   rs / rt operands
//   hi_cur    in   current HI, accumulated into by MADD/MSUB
//   lo_cur    in   current LO, accumulated into by MADD/MSUB
//   busy      out  operation in flight (PREP..WRITE)
//   done      out  one-cycle completion pulse
//   hi_write  out  HI write enable
//   lo_write  out  LO write enable
//   hi_wdata  out  HI write data, held between writes
//   lo_wdata  out  LO write data, held between writes
// CNT_W must satisfy 2**CNT_W > WIDTH.
// ---------------------------------------------------------------------------
module mul_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH,
    parameter int CNT_W = 6
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             start,
    input  logic             flush,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] hi_cur,
    input  logic [WIDTH-1:0] lo_cur,
    output logic             busy,
    output logic             done,
    output logic             hi_write,
    output logic             lo_write,
    output logic [WIDTH-1:0] hi_wdata,
    output logic [WIDTH-1:0] lo_wdata
);

    mdu_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] hiCur_q, hiCur_d;
    logic [WIDTH-1:0] loCur_q, loCur_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic [WIDTH-1:0] accHi_q, accHi_d;
    logic [WIDTH-1:0] accLo_q, accLo_d;
    logic             prodNeg_q, prodNeg_d;
    logic             remNeg_q, remNeg_d;
    logic [WIDTH-1:0] hiWdata_q, hiWdata_d;
    logic [WIDTH-1:0] loWdata_q, loWdata_d;

    logic             isDiv;
    logic             isSigned;
    logic             divZero;
    logic [WIDTH-1:0] absA;
    logic [WIDTH-1:0] absB;
    logic [WIDTH-1:0] stepHi;
    logic [WIDTH-1:0] stepLo;
    logic [WIDTH-1:0] quoFix;
    logic [WIDTH-1:0] remFix;
    logic [2*WIDTH-1:0] magProd;
    logic [2*WIDTH-1:0] sgnProd;
    logic [2*WIDTH-1:0] curPair;
    logic [2*WIDTH-1:0] mulRes;

    mdu_iter_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .isDiv_i (isDiv),
        .accHi_i (accHi_q),
        .accLo_i (accLo_q),
        .opnd_i  (opnd_q),
        .accHi_o (stepHi),
        .accLo_o (stepLo)
    );

    // Operation decode and sign handling on the latched operands.  The
    // magnitude of the most negative value is its own bit pattern, which is
    // still correct when read as unsigned.
    always_comb begin
        isDiv    = (op_q == OP_DIV) || (op_q == OP_DIVU);
        isSigned = !((op_q == OP_MULTU) || (op_q == OP_DIVU));
        divZero  = (b_q == '0);
        absA     = (isSigned && a_q[WIDTH-1]) ? -a_q : a_q;
        absB     = (isSigned && b_q[WIDTH-1]) ? -b_q : b_q;
    end

    // Result correction used in FIX.  prodNeg_q doubles as the quotient sign
    // for divides, since both are a[msb]^b[msb].
    always_comb begin
        magProd = {accHi_q, accLo_q};
        sgnProd = prodNeg_q ? -magProd : magProd;
        curPair = {hiCur_q, loCur_q};
        quoFix  = prodNeg_q ? -accLo_q : accLo_q;
        remFix  = remNeg_q ? -accHi_q : accHi_q;
        case (op_q)
            OP_MADD: mulRes = curPair + sgnProd;
            OP_MSUB: mulRes = curPair - sgnProd;
            default: mulRes = sgnProd;
        endcase
    end

    // Next-state logic.  A flush overrides everything, including a start in
    // IDLE and the FIX-cycle update of the write data, so a killed operation
    // leaves no trace on the outputs.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        hiCur_d   = hiCur_q;
        loCur_d   = loCur_q;
        opnd_d    = opnd_q;
        accHi_d   = accHi_q;
        accLo_d   = accLo_q;
        prodNeg_d = prodNeg_q;
        remNeg_d  = remNeg_q;
        hiWdata_d = hiWdata_q;
        loWdata_d = loWdata_q;

        if (flush) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start && opIsLegal(op)) begin
                        state_d = ST_PREP;
                        op_d    = op;
                        a_d     = a;
                        b_d     = b;
                        hiCur_d = hi_cur;
                        loCur_d = lo_cur;
                    end
                end
                ST_PREP: begin
                    accHi_d   = '0;
                    accLo_d   = absA;
                    opnd_d    = absB;
                    prodNeg_d = isSigned && (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
                    remNeg_d  = isSigned && isDiv && a_q[WIDTH-1];
                    cnt_d     = '0;
                    state_d   = ST_CALC;
                end
                ST_CALC: begin
                    accHi_d = stepHi;
                    accLo_d = stepLo;
                    cnt_d   = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        state_d = ST_FIX;
                    end
                end
                ST_FIX: begin
                    if (isDiv) begin
                        if (divZero) begin
                            hiWdata_d = a_q;
                            loWdata_d = WIDTH'(DIV0_LO);
                        end else begin
                            hiWdata_d = remFix;
                            loWdata_d = quoFix;
                        end
                    end else begin
                        hiWdata_d = mulRes[2*WIDTH-1:WIDTH];
                        loWdata_d = mulRes[WIDTH-1:0];
                    end
                    state_d = ST_WRITE;
                end
                ST_WRITE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State and datapath registers
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            hiCur_q   <= '0;
            loCur_q   <= '0;
            opnd_q    <= '0;
            accHi_q   <= '0;
            accLo_q   <= '0;
            prodNeg_q <= 1'b0;
            remNeg_q  <= 1'b0;
            hiWdata_q <= '0;
            loWdata_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            a_q       <= a_d;
            b_q       <= b_d;
            hiCur_q   <= hiCur_d;
            loCur_q   <= loCur_d;
            opnd_q    <= opnd_d;
            accHi_q   <= accHi_d;
            accLo_q   <= accLo_d;
            prodNeg_q <= prodNeg_d;
            remNeg_q  <= remNeg_d;
            hiWdata_q <= hiWdata_d;
            loWdata_q <= loWdata_d;
        end
    end

    // Status and strobes are decodes of the registered state, so reset
    // forces them low without waiting for a clock edge.
    assign busy     = (state_q != ST_IDLE);
    assign done     = (state_q == ST_WRITE);
    assign hi_write = (state_q == ST_WRITE);
    assign lo_write = (state_q == ST_WRITE);
    assign hi_wdata = hiWdata_q;
    assign lo_wdata = loWdata_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// ---------------------------------------------------------------------------
// tb_mul_div_unit
// Directed bench for mul_div_unit: arithmetic vectors with hand-computed
// HI/LO values, cycle-exact strobe/busy profile, and the control cases
// (start while busy, flush, flush with start, illegal op, async reset).
// ---------------------------------------------------------------------------
module tb_mul_div_unit;
    import mdu_pkg::*;

    logic        Clk;
    logic        Rst_n;
    logic        start;
    logic        flush;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi_cur;
    logic [31:0] lo_cur;
    logic        busy;
    logic        done;
    logic        hi_write;
    logic        lo_write;
    logic [31:0] hi_wdata;
    logic [31:0] lo_wdata;

    int total = 0;
    int bad   = 0;

    mul_div_unit #(
        .WIDTH (32),
        .CNT_W (6)
    ) dut (
        .Clk      (Clk),
        .Rst_n    (Rst_n),
        .start    (start),
        .flush    (flush),
        .op       (op),
        .a        (a),
        .b        (b),
        .hi_cur   (hi_cur),
        .lo_cur   (lo_cur),
        .busy     (busy),
        .done     (done),
        .hi_write (hi_write),
        .lo_write (lo_write),
        .hi_wdata (hi_wdata),
        .lo_wdata (lo_wdata)
    );

    // 10 ns clock
    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // Guard against a hung run
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Single comparison point
    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Present one request for exactly one rising edge; returns 1 ns into
    // cycle 1 (the PREP cycle if the request was accepted).
    task automatic applyStimulus(input logic [2:0] opV, input logic [31:0] aV, input logic [31:0] bV,
                                 input logic [31:0] hcV, input logic [31:0] lcV, input logic withFlush);
        @(negedge Clk);
        op     = opV;
        a      = aV;
        b      = bV;
        hi_cur = hcV;
        lo_cur = lcV;
        start  = 1'b1;
        flush  = withFlush;
        @(posedge Clk);
        #1;
        start = 1'b0;
        flush = 1'b0;
    endtask

    // mode = 0: normal op, strobes and data checked in cycle 35
    // mode > 0: flush asserted during cycle 'mode', busy low afterwards
    // mode < 0: request must have been ignored, busy never rises
    // glitch:   a different op is requested during cycle 5
    task automatic runOp(input string tag, input logic [2:0] opV, input logic [31:0] aV, input logic [31:0] bV,
                         input logic [31:0] hcV, input logic [31:0] lcV, input logic [31:0] expHi,
                         input logic [31:0] expLo, input int mode, input logic glitch, input logic withFlush);
        int busyBad;
        int strobeBad;
        int lastCyc;
        logic expBusy;
        logic expStrobe;
        busyBad   = 0;
        strobeBad = 0;
        lastCyc   = (mode == 0) ? 35 : 45;
        applyStimulus(opV, aV, bV, hcV, lcV, withFlush);
        for (int k = 1; k <= lastCyc; k++) begin
            expBusy   = (mode < 0) ? 1'b0 : ((mode > 0) ? (k <= mode) : 1'b1);
            expStrobe = (mode == 0) && (k == 35);
            if (busy !== expBusy) busyBad++;
            if (done !== expStrobe || hi_write !== expStrobe || lo_write !== expStrobe) strobeBad++;
            if (k == 35 && mode == 0) begin
                checkOutput({tag, " hi_wdata"}, {32'h0, hi_wdata}, {32'h0, expHi});
                checkOutput({tag, " lo_wdata"}, {32'h0, lo_wdata}, {32'h0, expLo});
            end
            if (glitch && k == 5) begin
                start = 1'b1;
                op    = OP_MULT;
                a     = 32'h3;
                b     = 32'h3;
            end
            if (glitch && k == 6) start = 1'b0;
            if (mode > 0 && k == mode) flush = 1'b1;
            if (mode > 0 && k == mode + 1) flush = 1'b0;
            @(posedge Clk);
            #1;
        end
        checkOutput({tag, " busy profile errors"}, 64'(busyBad), 64'd0);
        checkOutput({tag, " strobe profile errors"}, 64'(strobeBad), 64'd0);
        if (mode == 0) begin
            checkOutput({tag, " idle after write"}, {62'h0, busy, done}, 64'h0);
            checkOutput({tag, " data held"}, {hi_wdata, lo_wdata}, {expHi, expLo});
        end
    endtask

    initial begin
        int stray;
        Rst_n  = 1'b0;
        start  = 1'b0;
        flush  = 1'b0;
        op     = '0;
        a      = '0;
        b      = '0;
        hi_cur = '0;
        lo_cur = '0;
        #2;
        checkOutput("reset outputs", {60'h0, busy, done, hi_write, lo_write}, 64'h0);
        checkOutput("reset data", {hi_wdata, lo_wdata}, 64'h0);
        @(negedge Clk);
        Rst_n = 1'b1;

        // Arithmetic vectors
        runOp("MULT -2*3",    OP_MULT,  32'hFFFF_FFFE, 32'h3, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 0, 1'b0, 1'b0);
        runOp("MULTU max^2",  OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'hFFFF_FFFE, 32'h0000_0001, 0, 1'b0, 1'b0);
        runOp("MULT -1*-1",   OP_MULT,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0, 32'h1, 0, 1'b0, 1'b0);
        runOp("DIV -7/2",     OP_DIV,   32'hFFFF_FFF9, 32'h2, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0, 1'b0, 1'b0);
        runOp("DIV 7/-2",     OP_DIV,   32'h7, 32'hFFFF_FFFE, 32'h0, 32'h0, 32'h1, 32'hFFFF_FFFD, 0, 1'b0, 1'b0);
        runOp("DIVU 7/2",     OP_DIVU,  32'h7, 32'h2, 32'h0, 32'h0, 32'h1, 32'h3, 0, 1'b0, 1'b0);
        runOp("DIVU max/16",  OP_DIVU,  32'hFFFF_FFFF, 32'h10, 32'h0, 32'h0, 32'hF, 32'h0FFF_FFFF, 0, 1'b0, 1'b0);
        runOp("DIV by zero",  OP_DIV,   32'h0000_1234, 32'h0, 32'h0, 32'h0, 32'h0000_1234, 32'hFFFF_FFFF, 0, 1'b0, 1'b0);
        runOp("DIV min/-1",   OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0, 32'h8000_0000, 0, 1'b0, 1'b0);
        runOp("MADD carry",   OP_MADD,  32'h1, 32'h1, 32'h0, 32'hFFFF_FFFF, 32'h1, 32'h0, 0, 1'b0, 1'b0);
        runOp("MSUB borrow",  OP_MSUB,  32'h1, 32'h1, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0, 1'b0);

        // Control cases
        runOp("start while busy", OP_DIVU, 32'd100, 32'd7, 32'h0, 32'h0, 32'd2, 32'd14, 0, 1'b1, 1'b0);
        runOp("flush at 10",      OP_MULTU, 32'd5, 32'd5, 32'h0, 32'h0, 32'h0, 32'h0, 10, 1'b0, 1'b0);
        runOp("illegal op",       3'b110, 32'd5, 32'd5, 32'h0, 32'h0, 32'h0, 32'h0, -1, 1'b0, 1'b0);
        runOp("flush with start", OP_MULT, 32'd5, 32'd5, 32'h0, 32'h0, 32'h0, 32'h0, -1, 1'b0, 1'b1);

        // Flush in IDLE leaves the last written data untouched
        @(negedge Clk);
        flush = 1'b1;
        @(negedge Clk);
        flush = 1'b0;
        @(posedge Clk);
        #1;
        checkOutput("idle flush busy", {63'h0, busy}, 64'h0);
        checkOutput("idle flush data", {hi_wdata, lo_wdata}, {32'd2, 32'd14});

        // Asynchronous reset in the middle of CALC
        applyStimulus(OP_MULTU, 32'd5, 32'd5, 32'h0, 32'h0, 1'b0);
        repeat (8) @(posedge Clk);
        #4;
        Rst_n = 1'b0;
        #1;
        checkOutput("async reset outputs", {60'h0, busy, done, hi_write, lo_write}, 64'h0);
        checkOutput("async reset data", {hi_wdata, lo_wdata}, 64'h0);
        @(negedge Clk);
        Rst_n = 1'b1;
        stray = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge Clk);
            #1;
            if (busy !== 1'b0 || done !== 1'b0 || hi_write !== 1'b0 || lo_write !== 1'b0) stray++;
        end
        checkOutput("no activity after reset", 64'(stray), 64'd0);

        // Unit is usable again after reset
        runOp("MULTU after reset", OP_MULTU, 32'd5, 32'd5, 32'h0, 32'h0, 32'h0, 32'd25, 0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
